// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register (USR) and its serial controller.
//   usr_mode_e   : USR mode select {sel1,sel0}
//   ctrl_state_e : controller FSM state
package usr_pkg;

  typedef enum logic [1:0] {
    ModeHold = 2'b00,  // keep contents
    ModeShr  = 2'b01,  // shift toward LSB, 'right' enters the MSB
    ModeShl  = 2'b10,  // shift toward MSB, 'left' enters the LSB
    ModeLoad = 2'b11   // parallel load of 'i'
  } usr_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/usr_serial_ctrl.sv
// Serial transfer controller for an attached universal shift register (USR).
// A parallel word is loaded into the USR, shifted out one bit per enabled cycle
// while receive bits shift in from the opposite end, and the received word is
// then offered on a valid/ready output.
//   clk, clear_n                 : clock, asynchronous active-low reset (shared with the USR)
//   s_valid, s_ready, s_data     : parallel transmit word handshake
//   s_dir                        : 0 = LSB first (shift toward LSB), 1 = MSB first
//   shift_en                     : permits one shift step this cycle
//   ser_in, ser_out, ser_valid   : serial receive / transmit bit, shift-occurs strobe
//   m_valid, m_ready, m_data     : received word handshake
//   sel0, sel1, left, right, i   : USR mode select, serial inputs, parallel load data
//   o                            : USR contents fed back
module usr_serial_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned size = 4
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [size-1:0] s_data,
  input  logic            s_dir,
  input  logic            shift_en,
  input  logic            ser_in,
  output logic            ser_out,
  output logic            ser_valid,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [size-1:0] m_data,
  output logic            sel0,
  output logic            sel1,
  output logic            left,
  output logic            right,
  output logic [size-1:0] i,
  input  logic [size-1:0] o
);

  localparam int unsigned CntW = $clog2(size + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(size - 1);

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  usr_mode_e       mode;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    mode      = ModeHold;
    i         = '0;
    left      = 1'b0;
    right     = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;

    unique case (state_q)
      StIdle: begin
        s_ready = 1'b1;
        if (s_valid) begin
          mode    = ModeLoad;
          i       = s_data;
          dir_d   = s_dir;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // A deasserted shift_en leaves the USR in hold and cnt untouched.
        if (shift_en) begin
          ser_valid = 1'b1;
          if (!dir_q) begin
            mode    = ModeShr;
            ser_out = o[0];
            right   = ser_in;
          end else begin
            mode    = ModeShl;
            ser_out = o[size-1];
            left    = ser_in;
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // USR holds, so m_data stays stable until the word is taken.
        m_valid = 1'b1;
        m_data  = o;
        if (m_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign sel1 = mode[1];
  assign sel0 = mode[0];

endmodule

// File: tb/tb_usr_serial_ctrl.sv
// Self-checking bench for usr_serial_ctrl with a 4-bit universal shift register attached.
module tb_usr_serial_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         clear_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_dir;
  logic         shift_en;
  logic         ser_in;
  logic         ser_out;
  logic         ser_valid;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         sel0;
  logic         sel1;
  logic         left;
  logic         right;
  logic [W-1:0] i;
  logic [W-1:0] o;
  logic [W-1:0] usr_q;

  int checks;
  int failures;

  usr_serial_ctrl #(
    .size(W)
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_dir    (s_dir),
    .shift_en (shift_en),
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .sel0     (sel0),
    .sel1     (sel1),
    .left     (left),
    .right    (right),
    .i        (i),
    .o        (o)
  );

  // Attached universal shift register, sharing clear_n with the controller.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      usr_q <= '0;
    end else begin
      case ({sel1, sel0})
        2'b01:   usr_q <= {right, usr_q[W-1:1]};
        2'b10:   usr_q <= {usr_q[W-2:0], left};
        2'b11:   usr_q <= i;
        default: usr_q <= usr_q;
      endcase
    end
  end
  assign o = usr_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic         v_valid;
    logic [W-1:0] v_data;
    logic         v_dir;
    logic         v_en;
    logic         v_sin;
    logic         v_mrdy;
    logic [1:0]   e_sel;
    logic         e_sout;
    logic         e_svalid;
    logic         e_sready;
    logic         e_mvalid;
    logic [W-1:0] e_mdata;
    logic         e_left;
    logic         e_right;
    logic [W-1:0] e_i;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic sv, input logic [W-1:0] sd, input logic dir,
                              input logic en, input logic si, input logic mr,
                              input logic [1:0] sel, input logic so, input logic svl,
                              input logic srdy, input logic mvl, input logic [W-1:0] md,
                              input logic l, input logic r, input logic [W-1:0] ii);
    vec_t v;
    v.v_valid = sv;  v.v_data = sd;  v.v_dir = dir;   v.v_en = en;
    v.v_sin = si;    v.v_mrdy = mr;  v.e_sel = sel;   v.e_sout = so;
    v.e_svalid = svl; v.e_sready = srdy; v.e_mvalid = mvl; v.e_mdata = md;
    v.e_left = l;    v.e_right = r;  v.e_i = ii;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [W-1:0] sd, input logic dir,
                       input logic en, input logic si, input logic mr);
    s_valid = sv; s_data = sd; s_dir = dir; shift_en = en; ser_in = si; m_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".sel"}, {6'd0, sel1, sel0}, 8'd0);
    chk({nm, ".left"}, {7'd0, left}, 8'd0);
    chk({nm, ".right"}, {7'd0, right}, 8'd0);
    chk({nm, ".i"}, {4'd0, i}, 8'd0);
    chk({nm, ".ser_out"}, {7'd0, ser_out}, 8'd0);
    chk({nm, ".ser_valid"}, {7'd0, ser_valid}, 8'd0);
    chk({nm, ".m_valid"}, {7'd0, m_valid}, 8'd0);
    chk({nm, ".s_ready"}, {7'd0, s_ready}, 8'd1);
  endtask

  // Full transfer from IDLE with shift_en held 1 and m_ready 1 in DONE.
  task automatic transfer(input string nm, input logic [W-1:0] d, input logic dir,
                          input logic [W-1:0] sin_seq, input logic [W-1:0] sout_seq,
                          input logic [W-1:0] exp_md);
    drive(1'b1, d, dir, 1'b1, 1'b0, 1'b1);
    #1;
    chk({nm, ".accept"}, {6'd0, sel1, sel0, s_ready} >> 0, {5'd0, 3'b111});
    tick();
    for (int k = 0; k < W; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1, sin_seq[W-1-k], 1'b1);
      #1;
      chk($sformatf("%s.ser_out%0d", nm, k), {7'd0, ser_out}, {7'd0, sout_seq[W-1-k]});
      chk($sformatf("%s.ser_valid%0d", nm, k), {7'd0, ser_valid}, 8'd1);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk({nm, ".m_valid"}, {7'd0, m_valid}, 8'd1);
    chk({nm, ".m_data"}, {4'd0, m_data}, {4'd0, exp_md});
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int accepts;
    int last_acc;
    checks   = 0;
    failures = 0;

    // LSB-first word 1011 with ser_in 0,1,1,0, then MSB-first with ser_in 1,0,0,1.
    vecs[0]  = mk(1, 4'b1011, 0, 1, 0, 1,  2'b11, 0, 0, 1, 0, 4'b0000, 0, 0, 4'b1011);
    vecs[1]  = mk(0, 4'b0000, 0, 1, 0, 1,  2'b01, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[2]  = mk(0, 4'b0000, 0, 1, 1, 1,  2'b01, 1, 1, 0, 0, 4'b0000, 0, 1, 4'b0000);
    vecs[3]  = mk(0, 4'b0000, 0, 1, 1, 1,  2'b01, 0, 1, 0, 0, 4'b0000, 0, 1, 4'b0000);
    vecs[4]  = mk(0, 4'b0000, 0, 1, 0, 1,  2'b01, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[5]  = mk(0, 4'b0000, 0, 1, 0, 1,  2'b00, 0, 0, 0, 1, 4'b0110, 0, 0, 4'b0000);
    vecs[6]  = mk(0, 4'b0000, 0, 0, 0, 1,  2'b00, 0, 0, 1, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[7]  = mk(1, 4'b1011, 1, 1, 1, 1,  2'b11, 0, 0, 1, 0, 4'b0000, 0, 0, 4'b1011);
    vecs[8]  = mk(0, 4'b1111, 0, 1, 1, 1,  2'b10, 1, 1, 0, 0, 4'b0000, 1, 0, 4'b0000);
    vecs[9]  = mk(0, 4'b1111, 0, 1, 0, 1,  2'b10, 0, 1, 0, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[10] = mk(0, 4'b1111, 0, 1, 0, 1,  2'b10, 1, 1, 0, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[11] = mk(0, 4'b1111, 0, 1, 1, 1,  2'b10, 1, 1, 0, 0, 4'b0000, 1, 0, 4'b0000);
    vecs[12] = mk(0, 4'b0000, 0, 0, 0, 1,  2'b00, 0, 0, 0, 1, 4'b1001, 0, 0, 4'b0000);
    vecs[13] = mk(0, 4'b0000, 0, 0, 0, 1,  2'b00, 0, 0, 1, 0, 4'b0000, 0, 0, 4'b0000);

    clear_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_reset_outputs("reset");
    clear_n = 1'b1;
    tick();

    for (int n = 0; n < 14; n++) begin
      drive(vecs[n].v_valid, vecs[n].v_data, vecs[n].v_dir, vecs[n].v_en, vecs[n].v_sin,
            vecs[n].v_mrdy);
      #1;
      chk($sformatf("v%0d.sel", n), {6'd0, sel1, sel0}, {6'd0, vecs[n].e_sel});
      chk($sformatf("v%0d.ser_valid", n), {7'd0, ser_valid}, {7'd0, vecs[n].e_svalid});
      chk($sformatf("v%0d.s_ready", n), {7'd0, s_ready}, {7'd0, vecs[n].e_sready});
      chk($sformatf("v%0d.m_valid", n), {7'd0, m_valid}, {7'd0, vecs[n].e_mvalid});
      chk($sformatf("v%0d.left", n), {7'd0, left}, {7'd0, vecs[n].e_left});
      chk($sformatf("v%0d.right", n), {7'd0, right}, {7'd0, vecs[n].e_right});
      chk($sformatf("v%0d.i", n), {4'd0, i}, {4'd0, vecs[n].e_i});
      if (vecs[n].e_svalid) begin
        chk($sformatf("v%0d.ser_out", n), {7'd0, ser_out}, {7'd0, vecs[n].e_sout});
      end
      if (vecs[n].e_mvalid) begin
        chk($sformatf("v%0d.m_data", n), {4'd0, m_data}, {4'd0, vecs[n].e_mdata});
      end
      tick();
    end

    // Stall of 3 cycles after the 2nd shift, then a 5-cycle m_ready hold-off in DONE.
    drive(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall.ser_out0", {7'd0, ser_out}, 8'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("stall.ser_out1", {7'd0, ser_out}, 8'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      chk($sformatf("stall%0d.sel", k), {6'd0, sel1, sel0}, 8'd0);
      chk($sformatf("stall%0d.ser_valid", k), {7'd0, ser_valid}, 8'd0);
      chk($sformatf("stall%0d.m_valid", k), {7'd0, m_valid}, 8'd0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("stall.ser_out2", {7'd0, ser_out}, 8'd0);
    chk("stall.ser_valid2", {7'd0, ser_valid}, 8'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall.ser_out3", {7'd0, ser_out}, 8'd1);
    chk("stall.m_valid_early", {7'd0, m_valid}, 8'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("hold%0d.m_valid", k), {7'd0, m_valid}, 8'd1);
      chk($sformatf("hold%0d.m_data", k), {4'd0, m_data}, 8'b0110);
      chk($sformatf("hold%0d.s_ready", k), {7'd0, s_ready}, 8'd0);
      tick();
    end
    drive(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("hold.take.s_ready", {7'd0, s_ready}, 8'd0);
    chk("hold.take.m_valid", {7'd0, m_valid}, 8'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hold.after.s_ready", {7'd0, s_ready}, 8'd1);
    chk("hold.after.m_valid", {7'd0, m_valid}, 8'd0);
    tick();

    // Reset pulse after the 2nd shift of an MSB-first word.
    drive(1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    #2;
    clear_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midreset%0d.m_valid", k), {7'd0, m_valid}, 8'd0);
      if (k == 1) begin
        #3;
        clear_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    transfer("postreset", 4'b1011, 1'b1, 4'b1001, 4'b1011, 4'b1001);
    tick();

    // Back-to-back words with s_valid held: one accept every size+2 cycles.
    drive(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1);
    accepts  = 0;
    last_acc = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (s_ready) begin
        if (last_acc >= 0) begin
          chk($sformatf("b2b.gap%0d", accepts), 8'(c - last_acc), 8'(W + 2));
        end
        chk($sformatf("b2b.load%0d", accepts), {6'd0, sel1, sel0}, 8'd3);
        accepts++;
        last_acc = c;
      end
      if (m_valid) begin
        chk($sformatf("b2b.m_data%0d", c), {4'd0, m_data}, 8'b1111);
      end
      tick();
    end
    chk("b2b.accepts", 8'(accepts), 8'd4);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
